slfifo_write_ctrl: RTL and testbench

- Sequences 32-bit write bursts from a local data source into the FX3 GPIF II slave FIFO interface, with the CPLD acting as FIFO master.
- Gates writes on the FX3 DMA-ready and watermark flags, counts words per packet, and commits short packets with PKTEND_n when the source stops mid-packet.
- Sits between the data generator (counter or user stream) and the FX3 pins. Replaces free-running WR_n generation.

---
 rtl/slfifo_write_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_slfifo_write_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/slfifo_write_ctrl.sv
// FX3 GPIF II slave-FIFO write master: bursts source words onto DQ under FLAGA/FLAGB
// control, counts words per packet and commits short packets with PKTEND_n.
module slfifo_write_ctrl #(
  parameter int unsigned BURST_LEN   = 1024,
  parameter int unsigned GAP_CYCLES  = 3,
  parameter logic [1:0]  SOCKET_ADDR = 2'b00
) (
  input  logic        PCLK,
  input  logic        RESET_n,
  input  logic        START,
  input  logic        FLAG_RDY_n,
  input  logic        FLAG_WM_n,
  input  logic [31:0] SRC_DATA,
  input  logic        SRC_VALID,
  output logic        SRC_READY,
  output logic        SLCS_n,
  output logic        SLWR_n,
  output logic        PKTEND_n,
  output logic [1:0]  FIFOADDR,
  output logic [31:0] DQ,
  output logic [31:0] WORDS_SENT,
  output logic        BUSY
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_RDY = 3'd1,
    ST_WRITE    = 3'd2,
    ST_COMMIT   = 3'd3,
    ST_GAP      = 3'd4
  } state_t;

  localparam logic [15:0] LP_BURST = 16'(BURST_LEN);
  // The first GAP cycle carries the final SLWR_n/PKTEND_n strobe of the packet, so
  // loading GAP_CYCLES leaves exactly GAP_CYCLES strobe-idle cycles after it.
  localparam logic [3:0]  LP_GAP   = 4'(GAP_CYCLES);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_word_cnt;
  logic [15:0] w_word_cnt_nxt;
  logic [15:0] w_cnt_inc;
  logic [3:0]  r_gap_cnt;
  logic [3:0]  w_gap_cnt_nxt;
  logic        w_accept;

  logic        r_src_ready;
  logic        r_slcs_n;
  logic        r_slwr_n;
  logic        r_pktend_n;
  logic        r_busy;
  logic [1:0]  r_fifoaddr;
  logic [31:0] r_dq;
  logic [31:0] r_words_sent;

  // Source handshake: a word is taken when the registered ready meets a valid word
  always_comb begin
    w_accept  = 1'b0;
    w_cnt_inc = r_word_cnt;
    if ((r_state == ST_WRITE) && r_src_ready && SRC_VALID) begin
      w_accept = 1'b1;
    end else begin
      w_accept = 1'b0;
    end
    if (w_accept && (r_word_cnt != LP_BURST)) begin
      w_cnt_inc = r_word_cnt + 16'd1;
    end else begin
      w_cnt_inc = r_word_cnt;
    end
  end

  // Next-state, packet word count and gap timer
  always_comb begin
    w_state_nxt    = r_state;
    w_word_cnt_nxt = r_word_cnt;
    w_gap_cnt_nxt  = r_gap_cnt;
    case (r_state)
      ST_IDLE: begin
        if (START) begin
          w_state_nxt = ST_WAIT_RDY;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT_RDY: begin
        if (FLAG_RDY_n && FLAG_WM_n) begin
          w_state_nxt = ST_WRITE;
        end else if (!START) begin
          if (r_word_cnt != 16'd0) begin
            w_state_nxt = ST_COMMIT;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_state_nxt = ST_WAIT_RDY;
        end
      end
      ST_WRITE: begin
        w_word_cnt_nxt = w_cnt_inc;
        if (w_accept && (w_cnt_inc == LP_BURST)) begin
          // Full packets are committed by the FX3 itself
          w_state_nxt    = ST_GAP;
          w_word_cnt_nxt = 16'd0;
          w_gap_cnt_nxt  = LP_GAP;
        end else if (!FLAG_WM_n) begin
          w_state_nxt = ST_WAIT_RDY;
        end else if (!START) begin
          if (w_cnt_inc != 16'd0) begin
            w_state_nxt = ST_COMMIT;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_state_nxt = ST_WRITE;
        end
      end
      ST_COMMIT: begin
        w_state_nxt    = ST_GAP;
        w_word_cnt_nxt = 16'd0;
        w_gap_cnt_nxt  = LP_GAP;
      end
      ST_GAP: begin
        if (r_gap_cnt == 4'd0) begin
          if (START) begin
            w_state_nxt = ST_WAIT_RDY;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_gap_cnt_nxt = r_gap_cnt - 4'd1;
        end
      end
      default: begin
        w_state_nxt    = ST_IDLE;
        w_word_cnt_nxt = 16'd0;
        w_gap_cnt_nxt  = 4'd0;
      end
    endcase
  end

  // State register and counters, falling-edge domain
  always_ff @(negedge PCLK or negedge RESET_n) begin
    if (!RESET_n) begin
      r_state    <= ST_IDLE;
      r_word_cnt <= 16'd0;
      r_gap_cnt  <= 4'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_word_cnt <= w_word_cnt_nxt;
      r_gap_cnt  <= w_gap_cnt_nxt;
    end
  end

  // Registered pin drivers; control pins follow the state being entered
  always_ff @(negedge PCLK or negedge RESET_n) begin
    if (!RESET_n) begin
      r_src_ready  <= 1'b0;
      r_slcs_n     <= 1'b1;
      r_slwr_n     <= 1'b1;
      r_pktend_n   <= 1'b1;
      r_busy       <= 1'b0;
      r_fifoaddr   <= SOCKET_ADDR;
      r_dq         <= 32'd0;
      r_words_sent <= 32'd0;
    end else begin
      r_src_ready  <= (w_state_nxt == ST_WRITE) && START && FLAG_WM_n &&
                      (w_word_cnt_nxt < LP_BURST);
      r_slcs_n     <= (w_state_nxt == ST_IDLE);
      r_slwr_n     <= ~w_accept;
      // PKTEND_n pulses in the cycle after COMMIT so it never overlaps the last SLWR_n
      r_pktend_n   <= (r_state != ST_COMMIT);
      r_busy       <= (w_state_nxt != ST_IDLE);
      r_fifoaddr   <= SOCKET_ADDR;
      if (w_accept) begin
        r_dq         <= SRC_DATA;
        r_words_sent <= r_words_sent + 32'd1;
      end
    end
  end

  assign SRC_READY  = r_src_ready;
  assign SLCS_n     = r_slcs_n;
  assign SLWR_n     = r_slwr_n;
  assign PKTEND_n   = r_pktend_n;
  assign BUSY       = r_busy;
  assign FIFOADDR   = r_fifoaddr;
  assign DQ         = r_dq;
  assign WORDS_SENT = r_words_sent;

endmodule

// File: tb/tb_slfifo_write_ctrl.sv
// Directed bench for slfifo_write_ctrl (BURST_LEN=4, GAP_CYCLES=3): a vector table for
// streaming/gap/valid gaps plus hand sequences for flags, START drop and async reset.
module tb_slfifo_write_ctrl;

  logic        PCLK = 1'b1;
  logic        RESET_n;
  logic        START;
  logic        FLAG_RDY_n;
  logic        FLAG_WM_n;
  logic [31:0] SRC_DATA;
  logic        SRC_VALID;
  logic        SRC_READY;
  logic        SLCS_n;
  logic        SLWR_n;
  logic        PKTEND_n;
  logic [1:0]  FIFOADDR;
  logic [31:0] DQ;
  logic [31:0] WORDS_SENT;
  logic        BUSY;

  int   checks   = 0;
  int   failures = 0;
  int   n_wr     = 0;
  int   n_pk     = 0;
  logic src_auto = 1'b0;

  slfifo_write_ctrl #(.BURST_LEN(4), .GAP_CYCLES(3), .SOCKET_ADDR(2'b10)) dut (
    .PCLK(PCLK), .RESET_n(RESET_n), .START(START), .FLAG_RDY_n(FLAG_RDY_n),
    .FLAG_WM_n(FLAG_WM_n), .SRC_DATA(SRC_DATA), .SRC_VALID(SRC_VALID),
    .SRC_READY(SRC_READY), .SLCS_n(SLCS_n), .SLWR_n(SLWR_n), .PKTEND_n(PKTEND_n),
    .FIFOADDR(FIFOADDR), .DQ(DQ), .WORDS_SENT(WORDS_SENT), .BUSY(BUSY)
  );

  always #5 PCLK = ~PCLK;

  // ctl = {SLWR_n, PKTEND_n, SLCS_n, SRC_READY, BUSY}
  typedef struct {
    logic        start;
    logic        rdy_n;
    logic        wm_n;
    logic        valid;
    logic [31:0] data;
    logic [4:0]  ctl;
    logic [31:0] dq;
    logic [31:0] words;
  } vec_t;

  vec_t vecs[24];

  function automatic vec_t mk(input logic st, input logic rn, input logic wn, input logic v,
                              input logic [31:0] d, input logic [4:0] c,
                              input logic [31:0] q, input logic [31:0] w);
    vec_t r;
    r.start = st; r.rdy_n = rn; r.wm_n = wn; r.valid = v; r.data = d;
    r.ctl = c; r.dq = q; r.words = w;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ctl_now();
    return {27'd0, SLWR_n, PKTEND_n, SLCS_n, SRC_READY, BUSY};
  endfunction

  // One falling edge; lands 1ns after the following rising edge
  task automatic step();
    logic acc;
    acc = SRC_VALID && SRC_READY;
    @(posedge PCLK);
    #1;
    if (SLWR_n === 1'b0) n_wr++;
    if (PKTEND_n === 1'b0) n_pk++;
    if (src_auto && acc) SRC_DATA = SRC_DATA + 32'd1;
  endtask

  task automatic chk_reset(input string name);
    chk({name, "_ctl"}, {27'd0, SLCS_n, SLWR_n, PKTEND_n, SRC_READY, BUSY}, 32'h0000_001C);
    chk({name, "_dq"}, DQ, 32'd0);
    chk({name, "_words"}, WORDS_SENT, 32'd0);
    chk({name, "_addr"}, {30'd0, FIFOADDR}, 32'd2);
  endtask

  task automatic do_reset();
    RESET_n = 1'b0; START = 1'b0; FLAG_RDY_n = 1'b1; FLAG_WM_n = 1'b1;
    SRC_VALID = 1'b0; SRC_DATA = 32'd0; src_auto = 1'b0;
    #3;
    @(posedge PCLK);
    #1;
    chk_reset("reset");
    RESET_n = 1'b1;
    n_wr = 0;
    n_pk = 0;
  endtask

  initial begin
    // Two full packets back to back, then a packet with SRC_VALID toggling
    vecs[0]  = mk(1'b1, 1'b1, 1'b1, 1'b1, 32'd0, 5'b11001, 32'd0, 32'd0);
    vecs[1]  = mk(1'b1, 1'b1, 1'b1, 1'b1, 32'd0, 5'b11011, 32'd0, 32'd0);
    vecs[2]  = mk(1'b1, 1'b1, 1'b1, 1'b1, 32'd0, 5'b01011, 32'd0, 32'd1);
    vecs[3]  = mk(1'b1, 1'b1, 1'b1, 1'b1, 32'd1, 5'b01011, 32'd1, 32'd2);
    vecs[4]  = mk(1'b1, 1'b1, 1'b1, 1'b1, 32'd2, 5'b01011, 32'd2, 32'd3);
    vecs[5]  = mk(1'b1, 1'b1, 1'b1, 1'b1, 32'd3, 5'b01001, 32'd3, 32'd4);
    vecs[6]  = mk(1'b1, 1'b1, 1'b1, 1'b1, 32'd4, 5'b11001, 32'd3, 32'd4);
    vecs[7]  = mk(1'b1, 1'b1, 1'b1, 1'b1, 32'd4, 5'b11001, 32'd3, 32'd4);
    vecs[8]  = mk(1'b1, 1'b1, 1'b1, 1'b1, 32'd4, 5'b11001, 32'd3, 32'd4);
    vecs[9]  = mk(1'b1, 1'b1, 1'b1, 1'b1, 32'd4, 5'b11001, 32'd3, 32'd4);
    vecs[10] = mk(1'b1, 1'b1, 1'b1, 1'b1, 32'd4, 5'b11011, 32'd3, 32'd4);
    vecs[11] = mk(1'b1, 1'b1, 1'b1, 1'b1, 32'd4, 5'b01011, 32'd4, 32'd5);
    vecs[12] = mk(1'b1, 1'b1, 1'b1, 1'b1, 32'd5, 5'b01011, 32'd5, 32'd6);
    vecs[13] = mk(1'b1, 1'b1, 1'b1, 1'b1, 32'd6, 5'b01011, 32'd6, 32'd7);
    vecs[14] = mk(1'b1, 1'b1, 1'b1, 1'b1, 32'd7, 5'b01001, 32'd7, 32'd8);
    vecs[15] = mk(1'b1, 1'b1, 1'b1, 1'b1, 32'd8, 5'b11001, 32'd7, 32'd8);
    vecs[16] = mk(1'b1, 1'b1, 1'b1, 1'b1, 32'd8, 5'b11001, 32'd7, 32'd8);
    vecs[17] = mk(1'b1, 1'b1, 1'b1, 1'b1, 32'd8, 5'b11001, 32'd7, 32'd8);
    vecs[18] = mk(1'b1, 1'b1, 1'b1, 1'b1, 32'd8, 5'b11001, 32'd7, 32'd8);
    vecs[19] = mk(1'b1, 1'b1, 1'b1, 1'b1, 32'd8, 5'b11011, 32'd7, 32'd8);
    vecs[20] = mk(1'b1, 1'b1, 1'b1, 1'b1, 32'd8, 5'b01011, 32'd8, 32'd9);
    vecs[21] = mk(1'b1, 1'b1, 1'b1, 1'b0, 32'd9, 5'b11011, 32'd8, 32'd9);
    vecs[22] = mk(1'b1, 1'b1, 1'b1, 1'b1, 32'd9, 5'b01011, 32'd9, 32'd10);
    vecs[23] = mk(1'b1, 1'b1, 1'b1, 1'b0, 32'd10, 5'b11011, 32'd9, 32'd10);

    do_reset();
    for (int i = 0; i < 24; i++) begin
      START = vecs[i].start; FLAG_RDY_n = vecs[i].rdy_n; FLAG_WM_n = vecs[i].wm_n;
      SRC_VALID = vecs[i].valid; SRC_DATA = vecs[i].data;
      step();
      chk($sformatf("vec%0d_ctl", i), ctl_now(), {27'd0, vecs[i].ctl});
      chk($sformatf("vec%0d_dq", i), DQ, vecs[i].dq);
      chk($sformatf("vec%0d_words", i), WORDS_SENT, vecs[i].words);
    end
    chk("table_no_pktend", n_pk, 32'd0);

    // FLAGA low for 5 cycles holds off writes
    do_reset();
    src_auto = 1'b1; SRC_DATA = 32'd100; SRC_VALID = 1'b1; START = 1'b1; FLAG_RDY_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("rdy_hold%0d", i), {30'd0, SLWR_n, SRC_READY}, 32'd2);
    end
    FLAG_RDY_n = 1'b1;
    step();
    chk("rdy_release", {30'd0, SLWR_n, SRC_READY}, 32'd3);
    step();
    chk("rdy_first_wr", {31'd0, SLWR_n}, 32'd0);
    chk("rdy_first_dq", DQ, 32'd100);

    // Watermark drop after two words, resume completes the packet
    do_reset();
    src_auto = 1'b1; SRC_VALID = 1'b1; START = 1'b1;
    step(); step(); step();
    FLAG_WM_n = 1'b0;
    step();
    chk("wm_two_words", n_wr, 32'd2);
    for (int i = 0; i < 4; i++) step();
    chk("wm_hold_words", n_wr, 32'd2);
    chk("wm_hold_ready", {31'd0, SRC_READY}, 32'd0);
    FLAG_WM_n = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("wm_total_words", n_wr, 32'd4);
    chk("wm_no_pktend", n_pk, 32'd0);
    chk("wm_words_sent", WORDS_SENT, 32'd4);
    chk("wm_last_dq", DQ, 32'd3);
    chk("wm_gap_ctl", ctl_now(), 32'h0000_0019);

    // START drop after three words commits a short packet
    do_reset();
    src_auto = 1'b1; SRC_VALID = 1'b1; START = 1'b1;
    step(); step(); step(); step();
    START = 1'b0;
    step();
    chk("short_last_wr", {30'd0, SLWR_n, PKTEND_n}, 32'd1);
    chk("short_words", WORDS_SENT, 32'd3);
    chk("short_dq", DQ, 32'd2);
    step();
    chk("short_pktend", {30'd0, SLWR_n, PKTEND_n}, 32'd2);
    step(); step(); step();
    chk("short_gap_busy", ctl_now(), 32'h0000_0019);
    step();
    chk("short_idle", ctl_now(), 32'h0000_001C);
    chk("short_one_pktend", n_pk, 32'd1);

    // START drop with an empty packet goes straight to IDLE
    do_reset();
    START = 1'b1;
    step(); step(); step();
    START = 1'b0;
    step();
    chk("empty_idle", ctl_now(), 32'h0000_001C);
    for (int i = 0; i < 4; i++) step();
    chk("empty_no_strobes", n_pk + n_wr, 32'd0);

    // Asynchronous reset in the middle of a write burst
    do_reset();
    src_auto = 1'b1; SRC_DATA = 32'h50; SRC_VALID = 1'b1; START = 1'b1;
    step(); step(); step(); step();
    chk("arst_pre_wr", {31'd0, SLWR_n}, 32'd0);
    chk("arst_pre_words", WORDS_SENT, 32'd2);
    #2;
    RESET_n = 1'b0;
    #1;
    chk_reset("arst_now");
    @(posedge PCLK);
    #3;
    START = 1'b0;
    RESET_n = 1'b1;
    n_wr = 0;
    n_pk = 0;
    for (int i = 0; i < 6; i++) step();
    chk("arst_no_strobes", n_pk + n_wr, 32'd0);
    chk("arst_after", ctl_now(), 32'h0000_001C);
    chk("arst_words", WORDS_SENT, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
